bsg_tag_serializer: RTL and testbench

Single-clock bsg_tag packet transmitter, the sending end of the serial tag bus that feeds `bsg_tag_master_decentralized` instances in link pearls. It accepts tag commands on a ready/valid interface and shifts them out bit-serially on `tag_data_o`. Commands are either a tag-master reset sequence or an addressed client packet. It sits in the chip or FPGA-side bring-up logic and drives the `tag_data_i` pin of every pearl sharing the bus.

---
 rtl/bsg_tag_serializer.sv | 178 +++++++++++++++++
 tb/tb_bsg_tag_serializer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_tag_serializer.sv
// Bit-serial bsg_tag transmitter: takes master-reset or addressed client commands on a
// ready/valid port and shifts them out LSB first on a registered tag line.
module bsg_tag_serializer #(
  parameter int els_p               = 4,
  parameter int lg_width_p          = 4,
  parameter int max_payload_width_p = 16,
  parameter int master_reset_ones_p = 64,
  parameter int gap_cycles_p        = 1,
  localparam int id_w = (els_p == 1) ? 1 : $clog2(els_p)
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           cmd_v_i,
  output logic                           cmd_ready_and_o,
  input  logic                           cmd_master_reset_i,
  input  logic [id_w-1:0]                cmd_node_id_i,
  input  logic                           cmd_data_not_reset_i,
  input  logic [lg_width_p-1:0]          cmd_len_i,
  input  logic [max_payload_width_p-1:0] cmd_payload_i,
  output logic                           tag_data_o,
  output logic                           busy_o
);

  localparam int len_span  = 1 << lg_width_p;
  localparam int max_a     = (master_reset_ones_p > len_span) ? master_reset_ones_p : len_span;
  localparam int max_cnt   = (max_a > gap_cycles_p) ? max_a : gap_cycles_p;
  localparam int cnt_w     = $clog2(max_cnt + 1);
  localparam int fld_w     = (id_w > lg_width_p) ? id_w : lg_width_p;

  localparam logic [cnt_w-1:0] cnt_one     = cnt_w'(1);
  localparam logic [cnt_w-1:0] mreset_load = cnt_w'(master_reset_ones_p - 1);
  localparam logic [cnt_w-1:0] id_load     = cnt_w'(id_w - 1);
  localparam logic [cnt_w-1:0] len_load    = cnt_w'(lg_width_p - 1);
  localparam logic [cnt_w-1:0] gap_load    = cnt_w'(gap_cycles_p - 1);

  typedef enum logic [2:0] {
    IDLE, MRESET, START, ID, NR, LEN, PAY, GAP
  } state_e;

  state_e                         state_r, state_n;
  logic [cnt_w-1:0]               cnt_r, cnt_n;
  logic [fld_w-1:0]               fld_r, fld_n;
  logic [max_payload_width_p-1:0] pay_r, pay_n;
  logic                           nr_r, nr_n;
  logic [lg_width_p-1:0]          len_r, len_n;
  logic                           tag_r, tag_n;
  logic                           cnt_last;

  assign cnt_last        = (cnt_r == '0);
  assign cmd_ready_and_o = (state_r == IDLE);
  assign busy_o          = (state_r != IDLE);
  assign tag_data_o      = tag_r;

  // The counter holds "cycles remaining in this state minus one"; tag_n is the bit
  // that belongs to the state being entered, so the line is always register-driven.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    fld_n   = fld_r;
    pay_n   = pay_r;
    nr_n    = nr_r;
    len_n   = len_r;
    tag_n   = 1'b0;
    unique case (state_r)
      IDLE: begin
        if (cmd_v_i && cmd_ready_and_o) begin
          fld_n = fld_w'(cmd_node_id_i);
          nr_n  = cmd_data_not_reset_i;
          len_n = cmd_len_i;
          pay_n = cmd_payload_i;
          tag_n = 1'b1;
          if (cmd_master_reset_i) begin
            state_n = MRESET;
            cnt_n   = mreset_load;
          end else begin
            state_n = START;
            cnt_n   = '0;
          end
        end
      end
      MRESET: begin
        if (cnt_last) begin
          state_n = GAP;
          cnt_n   = gap_load;
        end else begin
          cnt_n = cnt_r - cnt_one;
          tag_n = 1'b1;
        end
      end
      START: begin
        state_n = ID;
        cnt_n   = id_load;
        tag_n   = fld_r[0];
        fld_n   = fld_r >> 1;
      end
      ID: begin
        if (cnt_last) begin
          // The field register is reused for the length once the id is out.
          state_n = NR;
          cnt_n   = '0;
          tag_n   = nr_r;
          fld_n   = fld_w'(len_r);
        end else begin
          cnt_n = cnt_r - cnt_one;
          tag_n = fld_r[0];
          fld_n = fld_r >> 1;
        end
      end
      NR: begin
        state_n = LEN;
        cnt_n   = len_load;
        tag_n   = fld_r[0];
        fld_n   = fld_r >> 1;
      end
      LEN: begin
        if (cnt_last) begin
          if (len_r == '0) begin
            state_n = GAP;
            cnt_n   = gap_load;
          end else begin
            state_n = PAY;
            cnt_n   = cnt_w'(len_r) - cnt_one;
            tag_n   = pay_r[0];
            pay_n   = pay_r >> 1;
          end
        end else begin
          cnt_n = cnt_r - cnt_one;
          tag_n = fld_r[0];
          fld_n = fld_r >> 1;
        end
      end
      PAY: begin
        // Zeros shifted in from the top cover lengths beyond the payload width.
        if (cnt_last) begin
          state_n = GAP;
          cnt_n   = gap_load;
        end else begin
          cnt_n = cnt_r - cnt_one;
          tag_n = pay_r[0];
          pay_n = pay_r >> 1;
        end
      end
      GAP: begin
        if (cnt_last) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_r - cnt_one;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      fld_r   <= '0;
      pay_r   <= '0;
      nr_r    <= 1'b0;
      len_r   <= '0;
      tag_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      fld_r   <= fld_n;
      pay_r   <= pay_n;
      nr_r    <= nr_n;
      len_r   <= len_n;
      tag_r   <= tag_n;
    end
  end

endmodule

// File: tb/tb_bsg_tag_serializer.sv
// Self-checking bench for bsg_tag_serializer: fixed vectors, back-to-back hold-off,
// mid-packet reset and randomized commands against a serial reference model.
module tb_bsg_tag_serializer;

  localparam int ONES = 8;
  localparam int GAP  = 1;
  localparam int IDW  = 2;
  localparam int LG   = 4;
  localparam int MAXP = 16;

  typedef struct packed {
    logic        mr;
    logic [1:0]  id;
    logic        nr;
    logic [3:0]  len;
    logic [15:0] payload;
  } cmd_t;

  typedef struct {
    cmd_t        cmd;
    logic [63:0] expSeq;
    int          expN;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic        cmd_v;
  logic        cmd_ready;
  logic        cmd_mr;
  logic [1:0]  cmd_id;
  logic        cmd_nr;
  logic [3:0]  cmd_len;
  logic [15:0] cmd_payload;
  logic        tag_data;
  logic        busy;

  int passed = 0;
  int total  = 0;
  int hsCount = 0;
  int cycleCount = 0;
  int lastHs = 0;
  int prevHs = 0;

  bsg_tag_serializer #(
    .els_p(4), .lg_width_p(LG), .max_payload_width_p(MAXP),
    .master_reset_ones_p(ONES), .gap_cycles_p(GAP)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .cmd_v_i(cmd_v), .cmd_ready_and_o(cmd_ready),
    .cmd_master_reset_i(cmd_mr), .cmd_node_id_i(cmd_id),
    .cmd_data_not_reset_i(cmd_nr), .cmd_len_i(cmd_len),
    .cmd_payload_i(cmd_payload),
    .tag_data_o(tag_data), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake monitor: counts accepted commands and remembers the cycles of the last two.
  always @(posedge clk) begin
    cycleCount <= cycleCount + 1;
    if (cmd_v && cmd_ready && reset_n) begin
      hsCount <= hsCount + 1;
      prevHs  <= lastHs;
      lastHs  <= cycleCount;
    end
  end

  function automatic cmd_t makeCmd(logic mr, logic [1:0] id, logic nr, logic [3:0] len,
                                   logic [15:0] payload);
    cmd_t c;
    c.mr = mr; c.id = id; c.nr = nr; c.len = len; c.payload = payload;
    return c;
  endfunction

  // Reference: the full line waveform after a handshake, as a bit list in time order.
  function automatic void modelSerial(input cmd_t c, output logic [63:0] seq, output int n);
    seq = '0;
    n = 0;
    if (c.mr) begin
      for (int i = 0; i < ONES; i++) begin seq[n] = 1'b1; n++; end
    end else begin
      seq[n] = 1'b1; n++;
      for (int i = 0; i < IDW; i++) begin seq[n] = c.id[i]; n++; end
      seq[n] = c.nr; n++;
      for (int i = 0; i < LG; i++) begin seq[n] = c.len[i]; n++; end
      for (int i = 0; i < int'(c.len); i++) begin
        seq[n] = (i < MAXP) ? c.payload[i] : 1'b0;
        n++;
      end
    end
    for (int i = 0; i < GAP; i++) begin seq[n] = 1'b0; n++; end
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic driveCmd(input cmd_t c);
    cmd_mr = c.mr; cmd_id = c.id; cmd_nr = c.nr; cmd_len = c.len; cmd_payload = c.payload;
  endtask

  // Called at a negedge: waits (bounded) for ready, then presents the command.
  task automatic applyStimulus(input cmd_t c, output bit ok);
    int waited;
    waited = 0;
    ok = 1'b1;
    while (cmd_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (cmd_ready !== 1'b1) begin
      checkOutput("ready_timeout", {63'd0, cmd_ready}, 64'd1);
      ok = 1'b0;
    end else begin
      driveCmd(c);
      cmd_v = 1'b1;
    end
  endtask

  task automatic collectBits(input int n, input bit keepValid, input cmd_t nextC,
                             output logic [63:0] seq, output bit holdOk);
    seq = '0;
    holdOk = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (keepValid) driveCmd(nextC);
        else cmd_v = 1'b0;
      end
      seq[i] = tag_data;
      if (busy !== 1'b1 || cmd_ready !== 1'b0) holdOk = 1'b0;
    end
  endtask

  task automatic runCommand(input string name, input cmd_t c, input logic [63:0] exp,
                            input int n);
    bit ok;
    bit hold;
    logic [63:0] seq;
    applyStimulus(c, ok);
    if (ok) begin
      collectBits(n, 1'b0, c, seq, hold);
      checkOutput({name, "_bits"}, seq, exp);
      checkOutput({name, "_busy_hold"}, {63'd0, hold}, 64'd1);
      @(negedge clk);
      checkOutput({name, "_ready_after"}, {62'd0, busy, cmd_ready}, 64'd1);
    end
  endtask

  task automatic runModelled(input string name, input cmd_t c);
    logic [63:0] exp;
    int n;
    modelSerial(c, exp, n);
    runCommand(name, c, exp, n);
  endtask

  vec_t vecs[5];

  initial begin
    bit ok, holdA, holdB;
    logic [63:0] seqA, seqB, expA, expB, mask;
    int nA, nB, hs0;
    cmd_t a, b, c;

    // Hand-derived waveforms, bit i = line value i cycles after the handshake cycle.
    vecs[0].cmd = makeCmd(1'b1, 2'd0, 1'b0, 4'd0, 16'h0);     vecs[0].expSeq = 64'h0FF;    vecs[0].expN = 9;
    vecs[1].cmd = makeCmd(1'b0, 2'd2, 1'b1, 4'd3, 16'h0005);  vecs[1].expSeq = 64'h53D;    vecs[1].expN = 12;
    vecs[2].cmd = makeCmd(1'b0, 2'd3, 1'b0, 4'd0, 16'hABCD);  vecs[2].expSeq = 64'h007;    vecs[2].expN = 9;
    vecs[3].cmd = makeCmd(1'b0, 2'd1, 1'b1, 4'd15, 16'hFFFF); vecs[3].expSeq = 64'h7FFFFB; vecs[3].expN = 24;
    vecs[4].cmd = makeCmd(1'b0, 2'd0, 1'b0, 4'd2, 16'hFFFE);  vecs[4].expSeq = 64'h221;    vecs[4].expN = 11;

    reset_n = 1'b0;
    cmd_v = 1'b0;
    driveCmd(makeCmd(1'b0, 2'd0, 1'b0, 4'd0, 16'h0));
    repeat (2) @(negedge clk);
    checkOutput("in_reset", {61'd0, tag_data, busy, cmd_ready}, 64'd1);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("idle_%0d", i), {61'd0, tag_data, busy, cmd_ready}, 64'd1);
    end

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      runCommand($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].expSeq, vecs[i].expN);
    end

    // Back-to-back: valid stays high across both commands; the second must wait.
    @(negedge clk);
    a = makeCmd(1'b0, 2'd2, 1'b1, 4'd5, 16'($urandom));
    b = makeCmd(1'b0, 2'd1, 1'b0, 4'd3, 16'($urandom));
    modelSerial(a, expA, nA);
    modelSerial(b, expB, nB);
    hs0 = hsCount;
    applyStimulus(a, ok);
    if (ok) begin
      collectBits(nA, 1'b1, b, seqA, holdA);
      @(negedge clk);
      checkOutput("b2b_ready_between", {63'd0, cmd_ready}, 64'd1);
      collectBits(nB, 1'b0, b, seqB, holdB);
      @(negedge clk);
      checkOutput("b2b_a_bits", seqA, expA);
      checkOutput("b2b_b_bits", seqB, expB);
      checkOutput("b2b_holdoff", {62'd0, holdA, holdB}, 64'd3);
      checkOutput("b2b_hs_count", 64'(hsCount - hs0), 64'd2);
      checkOutput("b2b_spacing", 64'(lastHs - prevHs), 64'(nA + 1));
    end

    // Abort in the payload: line must drop without waiting for a clock edge.
    @(negedge clk);
    c = makeCmd(1'b0, 2'd0, 1'b1, 4'd10, 16'hFFFF);
    modelSerial(c, expA, nA);
    applyStimulus(c, ok);
    if (ok) begin
      collectBits(10, 1'b0, c, seqA, holdA);
      mask = (64'd1 << 10) - 64'd1;
      checkOutput("mid_prefix", seqA & mask, expA & mask);
      checkOutput("mid_pre_reset_line", {63'd0, tag_data}, 64'd1);
      #2 reset_n = 1'b0;
      #1 checkOutput("mid_async_reset", {61'd0, tag_data, busy, cmd_ready}, 64'd1);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      runModelled("post_reset_mr", makeCmd(1'b1, 2'd0, 1'b0, 4'd0, 16'h0));
      runModelled("post_reset_pkt", makeCmd(1'b0, 2'd3, 1'b1, 4'd7, 16'h5A3C));
    end

    for (int i = 0; i < 30; i++) begin
      c = makeCmd($urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)), 1'($urandom),
                  4'($urandom_range(0, 15)), 16'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      runModelled($sformatf("rand%0d", i), c);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, passed %0d of %0d", passed, total);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
